// File: rtl/onchip_sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port (s2) between two Avalon-MM requesters.
// Latency: 0-cycle accept when uncontended; read data returns 1 cycle after accept.
// Backpressure: the losing requester sees waitrequest and holds its request; no queueing.
//
// Ports:
//   clk, reset              : system clock, synchronous active-high reset
//   m0_* / m1_*             : Avalon-MM slave side, one set per requester
//   sram_*                  : drive the SRAM's second port (address2, write2, ...)
//   sram_readdata           : SRAM output, valid one cycle after a read is issued
module onchip_sram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_chipselect,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_chipselect,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] sram_address,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata
);

  // last_grant: id of the most recent winner (1 after reset so m0 wins first).
  // pend_valid/pend_id: a read was issued last cycle, and by whom.
  logic last_grant;
  logic pend_valid;
  logic pend_id;

  logic req0, req1;
  logic grant0, grant1, any_grant;

  // Requests are masked during reset so nothing reaches the SRAM.
  assign req0 = m0_chipselect & ~reset;
  assign req1 = m1_chipselect & ~reset;

  // Under contention the master that did not win last time gets the port.
  assign grant0    = req0 & (~req1 | last_grant);
  assign grant1    = req1 & (~req0 | ~last_grant);
  assign any_grant = grant0 | grant1;

  assign m0_waitrequest = reset | (m0_chipselect & ~grant0);
  assign m1_waitrequest = reset | (m1_chipselect & ~grant1);

  assign sram_clken      = 1'b1;
  assign sram_chipselect = any_grant;

  // Issue mux: idle port drives zeros so the SRAM inputs are quiet.
  always_comb begin
    sram_address    = '0;
    sram_byteenable = '0;
    sram_write      = 1'b0;
    sram_writedata  = '0;
    if (grant0) begin
      sram_address    = m0_address;
      sram_byteenable = m0_byteenable;
      sram_write      = m0_write;
      sram_writedata  = m0_writedata;
    end else if (grant1) begin
      sram_address    = m1_address;
      sram_byteenable = m1_byteenable;
      sram_write      = m1_write;
      sram_writedata  = m1_writedata;
    end
  end

  // Return path: steer the SRAM output to whoever issued last cycle's read.
  // Reset suppresses a return for a read that was in flight.
  always_comb begin
    m0_readdatavalid = pend_valid & ~pend_id & ~reset;
    m1_readdatavalid = pend_valid &  pend_id & ~reset;
    m0_readdata      = m0_readdatavalid ? sram_readdata : '0;
    m1_readdata      = m1_readdatavalid ? sram_readdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      pend_valid <= 1'b0;
      pend_id    <= 1'b0;
    end else begin
      if (any_grant) begin
        last_grant <= grant1;
      end
      // A new issue overwrites the pending slot in the same edge the old
      // return is consumed, giving one access per cycle.
      pend_valid <= any_grant & ~sram_write;
      if (any_grant & ~sram_write) begin
        pend_id <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_onchip_sram_port_arbiter.sv
// Bench for onchip_sram_port_arbiter: behavioural 1024x32 SRAM with registered
// address, a per-cycle vector table, and hand-written reset-mid-read and
// sustained-contention sequences.
module tb_onchip_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_chipselect, m1_chipselect;
  logic        m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [31:0] sram_writedata, sram_readdata;

  always #5 clk = ~clk;

  onchip_sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_chipselect(m0_chipselect),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_chipselect(m1_chipselect),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_clken(sram_clken),
    .sram_readdata(sram_readdata)
  );

  // SRAM model: address registered, output unregistered, byte-lane writes.
  logic [31:0] mem [0:1023];
  logic [9:0]  addr_q = '0;
  assign sram_readdata = mem[addr_q];
  always @(posedge clk) begin
    if (sram_chipselect && sram_clken) begin
      addr_q <= sram_address;
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) mem[sram_address][b*8 +: 8] <= sram_writedata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        cs0, wr0; logic [9:0] a0; logic [31:0] wd0; logic [3:0] be0;
    logic        cs1, wr1; logic [9:0] a1; logic [31:0] wd1; logic [3:0] be1;
    logic        w0, w1, v0, v1;
    logic [31:0] r0, r1;
    logic        scs, swr;
    logic [9:0]  saddr;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rst,
                     input logic cs0, input logic wr0, input logic [9:0] a0, input logic [31:0] wd0, input logic [3:0] be0,
                     input logic cs1, input logic wr1, input logic [9:0] a1, input logic [31:0] wd1, input logic [3:0] be1,
                     input logic w0, input logic w1, input logic v0, input logic v1,
                     input logic [31:0] r0, input logic [31:0] r1,
                     input logic scs, input logic swr, input logic [9:0] saddr);
    vec_t v;
    v.rst = rst;
    v.cs0 = cs0; v.wr0 = wr0; v.a0 = a0; v.wd0 = wd0; v.be0 = be0;
    v.cs1 = cs1; v.wr1 = wr1; v.a1 = a1; v.wd1 = wd1; v.be1 = be1;
    v.w0 = w0; v.w1 = w1; v.v0 = v0; v.v1 = v1; v.r0 = r0; v.r1 = r1;
    v.scs = scs; v.swr = swr; v.saddr = saddr;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    m0_chipselect = v.cs0; m0_write = v.wr0; m0_address = v.a0; m0_writedata = v.wd0; m0_byteenable = v.be0;
    m1_chipselect = v.cs1; m1_write = v.wr1; m1_address = v.a1; m1_writedata = v.wd1; m1_byteenable = v.be1;
  endtask

  task automatic check(input vec_t v, input int row);
    chk("m0_waitrequest", row, {31'd0, m0_waitrequest}, {31'd0, v.w0});
    chk("m1_waitrequest", row, {31'd0, m1_waitrequest}, {31'd0, v.w1});
    chk("m0_readdatavalid", row, {31'd0, m0_readdatavalid}, {31'd0, v.v0});
    chk("m1_readdatavalid", row, {31'd0, m1_readdatavalid}, {31'd0, v.v1});
    chk("m0_readdata", row, m0_readdata, v.r0);
    chk("m1_readdata", row, m1_readdata, v.r1);
    chk("sram_chipselect", row, {31'd0, sram_chipselect}, {31'd0, v.scs});
    chk("sram_write", row, {31'd0, sram_write}, {31'd0, v.swr});
    chk("sram_address", row, {22'd0, sram_address}, {22'd0, v.saddr});
    chk("sram_clken", row, {31'd0, sram_clken}, 32'd1);
  endtask

  // One cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input vec_t v, input int row);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    check(v, row);
  endtask

  localparam logic [31:0] D1 = 32'h11111111;
  localparam logic [31:0] D2 = 32'h22222222;

  vec_t hv;
  int   rownum;
  logic g, gp;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = D1;
    mem[10'h020] = D2;
    reset = 1'b1;
    m0_chipselect = 0; m0_write = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
    m1_chipselect = 0; m1_write = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;

    //   rst cs0 wr0 a0  wd0  be0  cs1 wr1 a1  wd1  be1 | w0 w1 v0 v1 r0 r1 scs swr saddr
    // Reset held two cycles with both masters requesting.
    add(1, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 1,1,0,0, 0,0, 0,0,10'h000);
    add(1, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 1,1,0,0, 0,0, 0,0,10'h000);
    // Contention after release: m0 first, then alternating, data to its owner.
    add(0, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 0,1,0,0, 0,0,  1,0,10'h010);
    add(0, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 1,0,1,0, D1,0, 1,0,10'h020);
    add(0, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 0,1,0,1, 0,D2, 1,0,10'h010);
    add(0, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 1,0,1,0, D1,0, 1,0,10'h020);
    add(0, 0,0,0,0,0,          0,0,0,0,0,          0,0,0,1, 0,D2, 0,0,10'h000);
    // Byte lanes: m1 writes lanes 0 and 2 only, then reads back.
    add(0, 0,0,0,0,0,          1,1,10'h3FF,32'hAABBCCDD,4'h5, 0,0,0,0, 0,0, 1,1,10'h3FF);
    add(0, 0,0,0,0,0,          1,0,10'h3FF,0,4'hF,             0,0,0,0, 0,0, 1,0,10'h3FF);
    // m0 write issues in the same cycle m1's read data returns.
    add(0, 1,1,10'h005,32'hDEADBEEF,4'hF, 0,0,0,0,0, 0,0,0,1, 0,32'h00BB00DD, 1,1,10'h005);
    add(0, 1,0,10'h005,0,4'hF, 0,0,0,0,0,             0,0,0,0, 0,0, 1,0,10'h005);
    add(0, 0,0,0,0,0,          0,0,0,0,0,             0,0,1,0, 32'hDEADBEEF,0, 0,0,10'h000);
    // Nine more idle cycles (ten in total).
    for (int i = 0; i < 9; i++)
      add(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 0,0,10'h000);
    // Last winner was m0, so m1 takes the next contention.
    add(0, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 1,0,0,0, 0,0,  1,0,10'h020);
    add(0, 1,0,10'h010,0,4'hF, 1,0,10'h020,0,4'hF, 0,1,0,1, 0,D2, 1,0,10'h010);
    add(0, 0,0,0,0,0,          0,0,0,0,0,          0,0,1,0, D1,0, 0,0,10'h000);

    rownum = 0;
    foreach (vecs[i]) begin
      step(vecs[i], rownum);
      rownum++;
    end

    // Reset mid-read: m0 read accepted, reset next cycle drops the return.
    // Last winner before reset is m0, so only a reset restores m0 priority.
    hv = vecs[vecs.size()-1];
    hv.rst = 0; hv.cs0 = 1; hv.wr0 = 0; hv.a0 = 10'h010; hv.be0 = 4'hF; hv.cs1 = 0;
    hv.w0 = 0; hv.w1 = 0; hv.v0 = 0; hv.v1 = 0; hv.r0 = 0; hv.r1 = 0; hv.scs = 1; hv.swr = 0; hv.saddr = 10'h010;
    step(hv, 100);
    hv.rst = 1; hv.cs0 = 0;
    hv.w0 = 1; hv.w1 = 1; hv.scs = 0; hv.saddr = 0;
    step(hv, 101);
    hv.rst = 0;
    hv.w0 = 0; hv.w1 = 0;
    step(hv, 102);
    hv.cs0 = 1; hv.cs1 = 1; hv.wr1 = 0; hv.a1 = 10'h020; hv.be1 = 4'hF;
    hv.w0 = 0; hv.w1 = 1; hv.scs = 1; hv.saddr = 10'h010;
    step(hv, 103);
    hv.cs0 = 0; hv.cs1 = 0;
    hv.w0 = 0; hv.w1 = 0; hv.v0 = 1; hv.r0 = D1; hv.scs = 0; hv.saddr = 0;
    step(hv, 104);

    // Sustained contention: m0 won last, so m1 leads; each read returns
    // to its issuer on the following cycle.
    gp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      g = (i % 2 == 0) ? 1'b1 : 1'b0;
      hv.cs0 = 1; hv.cs1 = 1; hv.a0 = 10'h010; hv.a1 = 10'h020;
      hv.w0 = g; hv.w1 = ~g; hv.scs = 1; hv.swr = 0;
      hv.saddr = g ? 10'h020 : 10'h010;
      hv.v0 = (i > 0) && !gp; hv.v1 = (i > 0) && gp;
      hv.r0 = hv.v0 ? D1 : 32'h0; hv.r1 = hv.v1 ? D2 : 32'h0;
      step(hv, 200 + i);
      gp = g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
